// File: rtl/proc_pkg.sv
// Shared definitions for the mini processor: fetch FSM encoding, default field widths
// and the halt word used by the fetch sequencer, decoder and execute stage.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam int              ADDR_W_DEF    = 4;
    localparam int              DATA_W_DEF    = 8;
    localparam int              OPCODE_W_DEF  = DATA_W_DEF / 2;
    localparam int              OPERAND_W_DEF = DATA_W_DEF - OPCODE_W_DEF;
    localparam logic [7:0]      HALT_WORD_DEF = 8'hFF;

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter: synchronous load of the restart address or a jump target,
// increment with natural ADDR_W-bit wrap, otherwise hold.
module pc_counter #(
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_reset_i,
    input  logic              load_jump_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_reset_i)
            pc_d = RESET_PC;
        else if (load_jump_i)
            pc_d = jump_addr_i;
        else if (inc_i)
            pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers each fetched word and issues it over
// valid/ready; stops on the halt word. FETCH_PERF_EN adds a saturating issue counter.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic [DATA_W-1:0]     imem_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_W/2-1:0]   instr_opcode,
    output logic [DATA_W/2-1:0]   instr_operand,
    input  logic                  jump_en,
    input  logic [ADDR_W-1:0]     jump_addr,
    output logic                  halted,
    output logic [ADDR_W-1:0]     pc
`ifdef FETCH_PERF_EN
    ,
    output logic [7:0]            issue_cnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              pc_load_reset, pc_load_jump, pc_inc;
    logic              handshake;

    assign handshake = valid_q && instr_ready;

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        valid_d       = valid_q;
        halted_d      = halted_q;
        pc_load_reset = 1'b0;
        pc_load_jump  = 1'b0;
        pc_inc        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_load_reset = 1'b1;
                    state_d       = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_data == HALT_WORD) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    ir_d    = imem_data;
                    pc_inc  = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A jump replaces the increment that was applied when the word was fetched.
                if (handshake) begin
                    valid_d      = 1'b0;
                    pc_load_jump = jump_en;
                    state_d      = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    halted_d      = 1'b0;
                    pc_load_reset = 1'b1;
                    state_d       = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_reset_i (pc_load_reset),
        .load_jump_i  (pc_load_jump),
        .inc_i        (pc_inc),
        .jump_addr_i  (jump_addr),
        .pc_o         (pc)
    );

`ifdef FETCH_PERF_EN
    logic [7:0] issue_cnt_q, issue_cnt_d;
    logic       start_acc;

    assign start_acc = start && (state_q == ST_IDLE || state_q == ST_HALT);

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (start_acc)
            issue_cnt_d = '0;
        else if (handshake && issue_cnt_q != 8'hFF)
            issue_cnt_d = issue_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            issue_cnt_q <= '0;
        else
            issue_cnt_q <= issue_cnt_d;
    end

    assign issue_cnt = issue_cnt_q;
`else
    // Without the performance option there is no issue counter.
`endif

    assign imem_addr     = pc;
    assign instr_valid   = valid_q;
    assign halted        = halted_q;
    assign instr_opcode  = ir_q[DATA_W-1:DATA_W/2];
    assign instr_operand = ir_q[DATA_W/2-1:0];

endmodule
